// File: rtl/uart_cmd_parser_if.sv
// Register-write bus between the command parser and the register target.
//   wr_valid : write request from the parser
//   wr_ready : target accepts the write; transfer when both are high
//   wr_addr  : 8-bit write address
//   wr_data  : 8-bit write data
// master = parser side, slave = register target side.
interface uart_cmd_parser_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_cmd_parser.sv
// UART command parser: frames SYNC(0xA5) ADDR LEN payload CHK packets from a
// byte stream, verifies the XOR checksum and replays the payload as a burst of
// register writes at consecutive (8-bit wrapping) addresses.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   rx_data, rx_valid : received byte and its one-cycle strobe
//   wr (master)       : register-write handshake bus
//   busy              : high whenever the parser is not waiting for SYNC
//   pkt_ok            : pulse, packet fully accepted
//   err_chk/err_len/err_timeout/err_overrun : one-cycle error pulses
// Optional feature: define UART_CMD_TIMEOUT_EN to build the inter-byte
// timeout; without it err_timeout is tied low.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 120_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  uart_cmd_parser_if.master         wr,
  output logic                      busy,
  output logic                      pkt_ok,
  output logic                      err_chk,
  output logic                      err_len,
  output logic                      err_timeout,
  output logic                      err_overrun
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN + 1);
  localparam int unsigned PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  if (MAX_LEN < 1 || MAX_LEN > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_cmd_parser: MAX_LEN must be 1..16 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_SYNC, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_COMMIT
  } state_t;

  state_t           state_q;
  logic [7:0]       addr_q;
  logic [7:0]       chk_q;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       buf_q [MAX_LEN];
  logic             last_idx;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Index points at the final payload byte (valid only when len_q > 0).
  assign last_idx = (idx_q == IDX_W'(len_q - IDX_W'(1)));

  // Packet framing, checksum and write-burst sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      addr_q      <= '0;
      chk_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      for (int i = 0; i < int'(MAX_LEN); i++) buf_q[i] <= '0;
      wr.wr_valid <= 1'b0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
      busy        <= 1'b0;
      pkt_ok      <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      err_timeout <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      pkt_ok      <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      err_timeout <= 1'b0;
`endif
      case (state_q)
        S_SYNC: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_q <= S_ADDR;
            busy    <= 1'b1;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q  <= rx_data;
            chk_q   <= rx_data;
            state_q <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            chk_q <= chk_q ^ rx_data;
            idx_q <= '0;
            if (rx_data > 8'(MAX_LEN)) begin
              err_len <= 1'b1;
              state_q <= S_SYNC;
              busy    <= 1'b0;
            end else begin
              len_q   <= IDX_W'(rx_data);
              state_q <= (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            buf_q[PTR_W'(idx_q)] <= rx_data;
            chk_q <= chk_q ^ rx_data;
            if (last_idx) state_q <= S_CHK;
            else          idx_q   <= idx_q + IDX_W'(1);
          end
        end
        S_CHK: begin
          if (rx_valid) begin
            idx_q <= '0;
            if (rx_data != chk_q) begin
              err_chk <= 1'b1;
              state_q <= S_SYNC;
              busy    <= 1'b0;
            end else if (len_q == '0) begin
              pkt_ok  <= 1'b1;
              state_q <= S_SYNC;
              busy    <= 1'b0;
            end else begin
              state_q     <= S_COMMIT;
              wr.wr_valid <= 1'b1;
              wr.wr_addr  <= addr_q;
              wr.wr_data  <= buf_q[0];
            end
          end
        end
        S_COMMIT: begin
          // Bytes arriving mid-burst cannot be buffered; flag and drop them.
          if (rx_valid) err_overrun <= 1'b1;
          if (wr.wr_valid && wr.wr_ready) begin
            if (last_idx) begin
              wr.wr_valid <= 1'b0;
              pkt_ok      <= 1'b1;
              idx_q       <= '0;
              state_q     <= S_SYNC;
              busy        <= 1'b0;
            end else begin
              idx_q      <= idx_q + IDX_W'(1);
              wr.wr_addr <= addr_q + 8'(idx_q) + 8'd1;
              wr.wr_data <= buf_q[PTR_W'(idx_q + IDX_W'(1))];
            end
          end
        end
        default: begin
          state_q     <= S_SYNC;
          wr.wr_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
`ifdef UART_CMD_TIMEOUT_EN
      // Inter-byte watchdog, armed only while a packet is being received.
      if (state_q == S_SYNC || state_q == S_COMMIT || rx_valid) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_q       <= '0;
        err_timeout <= 1'b1;
        state_q     <= S_SYNC;
        busy        <= 1'b0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser.
module tb_uart_cmd_parser;
  localparam int unsigned TMO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       busy, pkt_ok, err_chk, err_len, err_timeout, err_overrun;

  uart_cmd_parser_if wr_bus ();

  uart_cmd_parser #(.MAX_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .wr          (wr_bus),
    .busy        (busy),
    .pkt_ok      (pkt_ok),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Event monitor on the falling edge: pulses and handshakes are stable here.
  int c_ok = 0, c_chk = 0, c_len = 0, c_tmo = 0, c_ovr = 0, c_wv = 0;
  logic [15:0] wr_log[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_ok)      c_ok++;
      if (err_chk)     c_chk++;
      if (err_len)     c_len++;
      if (err_timeout) c_tmo++;
      if (err_overrun) c_ovr++;
      if (wr_bus.wr_valid) c_wv++;
      if (wr_bus.wr_valid && wr_bus.wr_ready) wr_log.push_back({wr_bus.wr_addr, wr_bus.wr_data});
    end
  end

  int b_ok, b_chk, b_len, b_tmo, b_ovr, b_wv, b_wr;
  task automatic snap();
    b_ok = c_ok; b_chk = c_chk; b_len = c_len; b_tmo = c_tmo;
    b_ovr = c_ovr; b_wv = c_wv; b_wr = wr_log.size();
  endtask

  function automatic logic [15:0] wr_at(int i);
    if (b_wr + i < wr_log.size()) return wr_log[b_wr + i];
    return 16'hxxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait for the parser to return to SYNC, plus settle for pulses.
  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, 32'(busy), 32'd0);
    idle(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy),            32'd0);
    check({tag, "_wv"},    32'(wr_bus.wr_valid), 32'd0);
    check({tag, "_addr"},  32'(wr_bus.wr_addr),  32'd0);
    check({tag, "_data"},  32'(wr_bus.wr_data),  32'd0);
    check({tag, "_pulse"}, 32'({pkt_ok, err_chk, err_len, err_timeout, err_overrun}), 32'd0);
  endtask

  initial begin
    logic hold_ok;
    wr_bus.wr_ready = 1'b1;
    #12;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(2);

    // Basic two-byte write packet.
    snap();
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
    wait_idle("p1_idle");
    check("p1_nwr",  32'(wr_log.size() - b_wr), 32'd2);
    check("p1_wr0",  32'(wr_at(0)), 32'h1011);
    check("p1_wr1",  32'(wr_at(1)), 32'h1122);
    check("p1_ok",   32'(c_ok - b_ok), 32'd1);
    check("p1_err",  32'(c_chk - b_chk + c_len - b_len + c_ovr - b_ovr), 32'd0);

    // Bad checksum, then a good packet.
    snap();
    send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h00});
    wait_idle("p2_idle");
    check("p2_chk",  32'(c_chk - b_chk), 32'd1);
    check("p2_wv",   32'(c_wv - b_wv), 32'd0);
    check("p2_ok",   32'(c_ok - b_ok), 32'd0);
    snap();
    send_seq('{8'hA5, 8'h20, 8'h01, 8'h55, 8'h74});
    wait_idle("p3_idle");
    check("p3_wr0",  32'(wr_at(0)), 32'h2055);
    check("p3_ok",   32'(c_ok - b_ok), 32'd1);

    // Over-length packet, then an empty packet.
    snap();
    send_seq('{8'hA5, 8'h00, 8'h09});
    idle(1);
    check("p4_len",  32'(c_len - b_len), 32'd1);
    check("p4_busy", 32'(busy), 32'd0);
    snap();
    send_seq('{8'hA5, 8'h00, 8'h00, 8'h00});
    wait_idle("p5_idle");
    check("p5_ok",   32'(c_ok - b_ok), 32'd1);
    check("p5_nwr",  32'(wr_log.size() - b_wr), 32'd0);

    // Back-pressure, address wrap and overrun.
    snap();
    wr_bus.wr_ready = 1'b0;
    send_seq('{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC});
    hold_ok = wr_bus.wr_valid && wr_bus.wr_addr == 8'hFF && wr_bus.wr_data == 8'hAA;
    send_byte(8'h33);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      hold_ok = hold_ok && wr_bus.wr_valid && wr_bus.wr_addr == 8'hFF && wr_bus.wr_data == 8'hAA;
    end
    check("p6_hold", 32'(hold_ok), 32'd1);
    check("p6_ovr",  32'(c_ovr - b_ovr), 32'd1);
    check("p6_nwr0", 32'(wr_log.size() - b_wr), 32'd0);
    wr_bus.wr_ready = 1'b1;
    wait_idle("p6_idle");
    check("p6_wr0",  32'(wr_at(0)), 32'hFFAA);
    check("p6_wr1",  32'(wr_at(1)), 32'h00BB);
    check("p6_ok",   32'(c_ok - b_ok), 32'd1);

    // Stalled packet.
    snap();
    send_seq('{8'hA5, 8'h10});
    idle(TMO + 5);
`ifdef UART_CMD_TIMEOUT_EN
    check("p7_tmo",  32'(c_tmo - b_tmo), 32'd1);
    check("p7_busy", 32'(busy), 32'd0);
`else
    check("p7_tmo",  32'(c_tmo - b_tmo), 32'd0);
    check("p7_busy", 32'(busy), 32'd1);
`endif
    rst_n = 1'b0; #1;
    rst_n = 1'b1;
    idle(2);

    // Reset mid-packet.
    snap();
    send_seq('{8'hA5, 8'h10, 8'h03, 8'h11});
    rst_n = 1'b0; #1;
    check_reset_outputs("p8_rst");
    idle(2);
    rst_n = 1'b1;
    idle(10);
    check("p8_wv",   32'(c_wv - b_wv), 32'd0);
    snap();
    send_seq('{8'hA5, 8'h30, 8'h01, 8'h44, 8'h75});
    wait_idle("p9_idle");
    check("p9_wr0",  32'(wr_at(0)), 32'h3044);
    check("p9_ok",   32'(c_ok - b_ok), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
